// File: rtl/line_draw_pkg.sv
// Shared types and width constants for the Bresenham line rasteriser.
// Widths of the error terms are expressed as offsets from the coordinate width.
package line_draw_pkg;

    localparam int unsigned COORD_W_DEF = 9;

    // |dx| needs one extra bit, -|dy| a sign bit on top, err/e2 one more each
    localparam int unsigned DX_W_EXTRA  = 1;
    localparam int unsigned DY_W_EXTRA  = 2;
    localparam int unsigned ERR_W_EXTRA = 3;
    localparam int unsigned E2_W_EXTRA  = 4;

    localparam int unsigned ERR_W = COORD_W_DEF + ERR_W_EXTRA;
    localparam int unsigned E2_W  = COORD_W_DEF + E2_W_EXTRA;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/line_draw_if.sv
// Endpoint-in / pixel-out bundle between the register slave, the rasteriser
// and the framebuffer writer. master = rasteriser side, slave = environment side.
interface line_draw_if
    import line_draw_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF
) ();

    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic               DataValid;

    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               pix_valid;
    logic               pix_ready;

    logic               busy;
    logic               done;

    modport master (
        input  x1, y1, x2, y2, DataValid, pix_ready,
        output pix_x, pix_y, pix_valid, busy, done
    );

    modport slave (
        output x1, y1, x2, y2, DataValid, pix_ready,
        input  pix_x, pix_y, pix_valid, busy, done
    );

endinterface

// File: rtl/line_draw.sv
// Bresenham line rasteriser: latches endpoints on a DataValid rising edge and
// streams one pixel per accepted handshake. Optional clipping: LINE_DRAW_CLIP_EN.
module line_draw
    import line_draw_pkg::*;
#(
    parameter int unsigned COORD_W  = COORD_W_DEF,
    parameter int unsigned SCREEN_W = 320,
    parameter int unsigned SCREEN_H = 240
) (
    input  logic        HCLK,
    input  logic        HRESET,
    line_draw_if.master bus
);

    localparam int unsigned DxW  = COORD_W + DX_W_EXTRA;
    localparam int unsigned DyW  = COORD_W + DY_W_EXTRA;
    localparam int unsigned ErrW = COORD_W + ERR_W_EXTRA;
    localparam int unsigned E2W  = COORD_W + E2_W_EXTRA;

    state_e                    state_q, state_d;
    logic                      dv_q, dv_d;
    logic                      armed_q, armed_d;
    logic        [COORD_W-1:0] cur_x_q, cur_x_d;
    logic        [COORD_W-1:0] cur_y_q, cur_y_d;
    logic        [COORD_W-1:0] end_x_q, end_x_d;
    logic        [COORD_W-1:0] end_y_q, end_y_d;
    logic        [DxW-1:0]     dx_q, dx_d;
    logic signed [DyW-1:0]     dy_q, dy_d;
    logic signed [ErrW-1:0]    err_q, err_d;
    logic                      sx_q, sx_d;
    logic                      sy_q, sy_d;
    logic                      pix_valid_q, pix_valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      start_c;
    logic                      step_c;
    logic                      at_end_c;
    logic                      x_move_c;
    logic                      y_move_c;
    logic                      vis_c;
    logic        [COORD_W-1:0] dx_abs_c;
    logic        [COORD_W-1:0] dy_abs_c;
    logic signed [E2W-1:0]     e2_c;
    logic signed [ErrW-1:0]    err_dx_c;
    logic signed [ErrW-1:0]    err_dy_c;

    always_comb begin
        state_d     = state_q;
        dv_d        = bus.DataValid;
        armed_d     = 1'b1;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        end_x_d     = end_x_q;
        end_y_d     = end_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        sx_d        = sx_q;
        sy_d        = sy_q;

        // armed_q masks a DataValid level that is already high when reset releases
        start_c     = bus.DataValid & ~dv_q & armed_q;
        at_end_c    = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
        // clipped pixels have pix_valid low and advance without a handshake
        step_c      = (state_q == DRAW) && (bus.pix_ready || !pix_valid_q);

        dx_abs_c    = (end_x_q >= cur_x_q) ? (end_x_q - cur_x_q) : (cur_x_q - end_x_q);
        dy_abs_c    = (end_y_q >= cur_y_q) ? (end_y_q - cur_y_q) : (cur_y_q - end_y_q);

        e2_c        = {err_q, 1'b0};
        x_move_c    = e2_c >= E2W'(dy_q);
        y_move_c    = e2_c <= $signed(E2W'(dx_q));
        err_dy_c    = x_move_c ? ErrW'(dy_q) : ErrW'(0);
        err_dx_c    = y_move_c ? $signed(ErrW'(dx_q)) : ErrW'(0);

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    cur_x_d = bus.x1;
                    cur_y_d = bus.y1;
                    end_x_d = bus.x2;
                    end_y_d = bus.y2;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                dx_d    = DxW'(dx_abs_c);
                dy_d    = -$signed(DyW'(dy_abs_c));
                sx_d    = cur_x_q < end_x_q;
                sy_d    = cur_y_q < end_y_q;
                err_d   = $signed(ErrW'(dx_abs_c)) - $signed(ErrW'(dy_abs_c));
                state_d = DRAW;
            end

            DRAW: begin
                if (step_c) begin
                    if (at_end_c) begin
                        state_d = DONE;
                    end else begin
                        if (x_move_c) begin
                            cur_x_d = sx_q ? (cur_x_q + COORD_W'(1)) : (cur_x_q - COORD_W'(1));
                        end
                        if (y_move_c) begin
                            cur_y_d = sy_q ? (cur_y_q + COORD_W'(1)) : (cur_y_q - COORD_W'(1));
                        end
                        err_d = err_q + err_dy_c + err_dx_c;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef LINE_DRAW_CLIP_EN
        vis_c = (32'(cur_x_d) < SCREEN_W) && (32'(cur_y_d) < SCREEN_H);
`else
        vis_c = 1'b1;
`endif

        // outputs describe the state being entered so they can be registered
        pix_valid_d = (state_d == DRAW) && vis_c;
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= IDLE;
            dv_q        <= 1'b0;
            armed_q     <= 1'b0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            end_x_q     <= '0;
            end_y_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dv_q        <= dv_d;
            armed_q     <= armed_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            end_x_q     <= end_x_d;
            end_y_q     <= end_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.pix_x     = cur_x_q;
    assign bus.pix_y     = cur_y_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: doc/line_draw.md
# line_draw

Bresenham line-rasteriser stage fed directly by the AHB-Lite endpoint register slave. It captures the four 9-bit endpoint coordinates (x1, y1, x2, y2) when DataValid rises, then emits every pixel of the line, one per cycle, over a valid/ready stream towards the framebuffer writer. A busy flag lets firmware poll for completion via the status path.

## Interface
Parameters:
- COORD_W, 9, coordinate width in bits (matches slave register width)
- SCREEN_W, 320, visible width in pixels (used only with clipping)
- SCREEN_H, 240, visible height in pixels (used only with clipping)

Ports:
- HCLK  input  1  system clock; all state on rising edge
- HRESET  input  1  asynchronous, active-high reset
- x1, y1, x2, y2  input  COORD_W each  line endpoints from register slave
- DataValid  input  1  level from slave; rising edge = start request
- pix_x, pix_y  output  COORD_W each  current pixel coordinate
- pix_valid  output  1  pix_x/pix_y hold a pixel to be written
- pix_ready  input  1  downstream accepts pixel this cycle
- busy  output  1  high from start capture until line complete
- done  output  1  single-cycle pulse after last pixel accepted

## Operation
- States: IDLE, SETUP, DRAW, DONE.
- IDLE: register DataValid each cycle; start = DataValid & !DataValid_q. On start, latch x1/y1/x2/y2 -> SETUP. Edges arriving outside IDLE are ignored (not queued).
- SETUP (1 cycle): dx = |x2-x1| (10-bit unsigned), dy = -|y2-y1| (11-bit signed), sx = +1 if x1<x2 else -1, sy likewise, err = dx+dy (12-bit signed); cur = (x1,y1) -> DRAW.
- DRAW: pix_valid=1, pix_x/pix_y=cur. On pix_valid & pix_ready: if cur==(x2,y2) -> DONE; else e2 = 2*err (13-bit signed); if e2>=dy {err+=dy; cur_x+=sx}; if e2<=dx {err+=dx; cur_y+=sy}; both may apply in one step. Without pix_ready, all state and outputs hold.
- DONE (1 cycle): done=1 -> IDLE.
- Pixel count = max(dx,|dy|)+1; zero-length line (endpoints equal) emits exactly one pixel.
- Coordinates never wrap: stepping always moves toward the latched end point; no out-of-range intermediate values.
- Endpoint inputs may change after latch with no effect on the line in progress.
- Reset (any state): state=IDLE, pix_x=pix_y=0, pix_valid=0, busy=0, done=0, DataValid_q=0, internal regs 0. A DataValid already high at reset release does not start a line (needs a fresh rising edge).

## Timing
- Edge sampled at cycle N -> SETUP at N+1 -> first pixel valid at N+2.
- With pix_ready held high: one pixel per cycle; last pixel accepted at cycle N+1+count, done high at N+2+count, busy low from N+3+count.
- busy high in SETUP, DRAW, DONE; low only in IDLE.
- pix_valid never drops without acceptance (AXI-style stable-while-stalled rule); pix_x/pix_y stable while pix_valid & !pix_ready.
- All outputs registered; no combinational path from pix_ready to pix_valid.

## Configuration
- LINE_DRAW_CLIP_EN defined: pixels with cur_x>=SCREEN_W or cur_y>=SCREEN_H are stepped over internally without asserting pix_valid (one cycle each, no handshake); done still follows the final step even if it was clipped.
- Not defined: every rasterised pixel is emitted; SCREEN_W/SCREEN_H unused.

## Structure
- Package line_draw_pkg: state enum (IDLE, SETUP, DRAW, DONE), COORD_W default constant, err/e2 width constants.
- No sub-module; edge detect, setup and Bresenham step live in one module.

## Test plan
- (0,0)->(3,0), ready=1 -> pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles; done 1 cycle after last; busy spans start+1..done.
- (5,5)->(2,2) -> (5,5),(4,4),(3,3),(2,2); steep (0,0)->(1,3) -> (0,0),(0,1),(1,2),(1,3).
- (7,7)->(7,7) -> exactly one pixel (7,7), then done.
- (0,0)->(3,0) with pix_ready low on alternate cycles -> same 4 pixels, each held stable until accepted, no duplicates or drops.
- Second DataValid edge during DRAW ignored; HRESET asserted mid-line -> all outputs 0 next edge, new edge after release draws cleanly from its x1,y1.
- LINE_DRAW_CLIP_EN, SCREEN_W=320: (318,0)->(321,0) -> only (318,0),(319,0) emitted, done still pulses.
